vector_exec_unit: RTL and testbench
===================================

Name: vector_exec_unit

Overview:
- Parametrised vector execution unit: internal vector register file, NUM_LANES-wide SIMD ALU, strided load/store engine on a valid/ready memory port.
- Per-element masking from register 0.
- Sits under the core's issue logic. Takes one vector instruction per start pulse and signals completion with done.

Parameters:
- NUM_LANES, 4, elements processed per ALU cycle; MAX_VL must be a multiple of it.
- DATA_WIDTH, 32, element width in bits.
- NUM_REGS, 8, number of vector registers.
- MAX_VL, 16, elements per vector register.
- ADDR_W, 32, memory address width.
- Derived: RIDX_W = clog2(NUM_REGS), VL_W = clog2(MAX_VL+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle instruction issue; sampled only in IDLE.
- funct  in  4  opcode; encoding in vec_pkg.
- vd, vs1, vs2  in  RIDX_W each  destination and source registers.
- vl  in  VL_W  requested vector length.
- mask_en  in  1  when 1, element i is active only if bit 0 of v0[i] is 1.
- base_addr  in  ADDR_W  load/store base address.
- stride  in  ADDR_W  two's-complement address increment between elements.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done for an illegal funct.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_WIDTH  load data.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State to IDLE.
  - busy, done, err, mem_req, mem_we drive 0; mem_addr and mem_wdata drive 0.
  - All register-file entries clear to 0.
  - An in-flight memory response arriving after reset is ignored.
- Operands latched at start:
  - funct, vd, vs1, vs2, mask_en, base_addr, stride.
  - eff_vl = min(vl, MAX_VL).
  - start while busy is ignored.
- States and transitions:
  - IDLE --start--> ALU, LD_REQ, ST_REQ or DONE.
  - DONE is entered directly when eff_vl == 0 or funct is illegal.
  - ALU: each cycle processes elements [k*NUM_LANES, k*NUM_LANES+NUM_LANES-1] that are < eff_vl; k increments each cycle. After the last chunk -> DONE. Latency is start + ceil(eff_vl/NUM_LANES) + 1 cycles to done.
  - LD_REQ: mem_req=1, mem_we=0, mem_addr = base_addr + i*stride (mod 2^ADDR_W). Hold all request outputs stable until mem_gnt, then -> LD_WAIT.
  - LD_WAIT: on mem_rvalid, write mem_rdata to vd[i] (if active), then i++. If i == eff_vl -> DONE, else -> LD_REQ. Only one outstanding request at a time.
  - ST_REQ: mem_req=1, mem_we=1, mem_wdata = vs2[i]. On mem_gnt, i++; if i == eff_vl -> DONE.
  - DONE: done=1 for one cycle (err=1 too if illegal), busy=0, then -> IDLE.
- Masked-off elements:
  - ALU/load: vd[i] is unchanged.
  - Store: no memory request is issued; the element is skipped in 1 cycle.
- ALU arithmetic (modulo 2^DATA_WIDTH):
  - ADD, SUB (vs1 - vs2), MUL (low DATA_WIDTH bits), AND, OR, XOR.
  - MIN and MAX are signed.
  - Sources are read combinationally; the write to vd occurs at the end of the same cycle. vd == vs1 or vd == vs2 is legal, because each chunk reads before it writes.
- Elements >= eff_vl are never written.
- Illegal funct: no register or memory side effects.

Decomposition:
- vec_pkg:
  - funct encoding: VADD=0, VSUB=1, VMUL=2, VAND=3, VOR=4, VXOR=5, VMIN=6, VMAX=7, VLD=8, VST=9; 10–15 illegal.
  - State enum: IDLE, ALU, LD_REQ, LD_WAIT, ST_REQ, DONE.
- Sub-module vec_lane_alu: combinational, one element per instance (funct, a, b -> result), instantiated NUM_LANES times by generate.

Test Plan:
- Load/add/store round trip: VLD v1 (base 0x100, stride 4, vl=16, memory holds 1..16), VLD v2 holding 100..115, VADD v3=v1+v2, VST v3 to 0x200 -> memory 0x200.. reads 101,103,...,131. The VADD done asserts exactly 5 cycles after start.
- Masking and signed ops: v0 = alternating 1/0, mask_en=1, VMAX v3=v1,v2 with v1[i]=-5, v2[i]=3 -> even elements become 3, odd elements keep their prior value. A masked VST issues exactly 8 requests.
- Memory backpressure and latency: mem_gnt delayed 3 cycles, rvalid 2 cycles later, vl=5 -> request outputs stay stable while waiting; all 5 elements load correctly. Negative stride -4 from 0x10 gives addresses 0x10, 0xC, 0x8, 0x4, 0x0.
- Boundaries:
  - vl=0 -> done 1 cycle after start, no writes, no requests.
  - vl=20 -> clamped to 16.
  - vl=6 -> only elements 0–5 change.
  - VMUL 0x80000000*2 -> 0.
  - Address 0xFFFFFFFC + 4 wraps to 0.
- Protocol errors: funct=12 -> done and err pulse together, no side effects. A second start while busy is ignored.
- Reset mid-LD_WAIT: assert rst asynchronously -> mem_req and busy drop immediately, registers read 0, a late mem_rvalid is ignored, and the next instruction executes normally.

Source files
------------

// File: rtl/vec_pkg.sv
// Purpose: shared encodings for the vector execution unit (opcodes, FSM states, opcode helpers).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vec_pkg;

  typedef enum logic [3:0] {
    VADD = 4'd0,
    VSUB = 4'd1,
    VMUL = 4'd2,
    VAND = 4'd3,
    VOR  = 4'd4,
    VXOR = 4'd5,
    VMIN = 4'd6,
    VMAX = 4'd7,
    VLD  = 4'd8,
    VST  = 4'd9
  } funct_e;

  typedef enum logic [2:0] {
    IDLE,
    ALU,
    LD_REQ,
    LD_WAIT,
    ST_REQ,
    DONE
  } state_e;

  // Opcodes 10..15 are reserved and complete with err.
  function automatic logic is_legal(input logic [3:0] f);
    return f <= 4'(VST);
  endfunction

  function automatic logic is_alu(input logic [3:0] f);
    return f <= 4'(VMAX);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Purpose: one SIMD lane; ports funct (opcode), a/b (operands), result (a op b, modulo 2^DATA_WIDTH).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; result is valid whenever the inputs are.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            funct,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (funct)
      VADD: result = a + b;
      VSUB: result = a - b;
      VMUL: result = a * b;
      VAND: result = a & b;
      VOR:  result = a | b;
      VXOR: result = a ^ b;
      VMIN: result = ($signed(a) < $signed(b)) ? a : b;
      VMAX: result = ($signed(a) < $signed(b)) ? b : a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vector_exec_unit.sv
// Purpose: vector unit with register file, NUM_LANES-wide ALU and strided load/store engine.
//   Ports: clk/rst; issue (start, funct, vd, vs1, vs2, vl, mask_en, base_addr, stride);
//   status (busy, done, err); memory port (mem_req/we/addr/wdata out, mem_gnt/rvalid/rdata in).
// Latency: ALU = ceil(eff_vl/NUM_LANES)+1 cycles start->done; vl=0 or illegal op = 1 cycle.
// Backpressure: request outputs held stable until mem_gnt; one outstanding load at a time.
module vector_exec_unit
  import vec_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int MAX_VL     = 16,
  parameter int ADDR_W     = 32,
  localparam int RIDX_W    = $clog2(NUM_REGS),
  localparam int VL_W      = $clog2(MAX_VL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            funct,
  input  logic [RIDX_W-1:0]     vd,
  input  logic [RIDX_W-1:0]     vs1,
  input  logic [RIDX_W-1:0]     vs2,
  input  logic [VL_W-1:0]       vl,
  input  logic                  mask_en,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     stride,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int EL_W = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;

  // Packed so the whole file clears in one reset assignment.
  logic [NUM_REGS-1:0][MAX_VL-1:0][DATA_WIDTH-1:0] rf;

  state_e              state;
  logic [3:0]          funct_q;
  logic [RIDX_W-1:0]   vd_q;
  logic [RIDX_W-1:0]   vs1_q;
  logic [RIDX_W-1:0]   vs2_q;
  logic                mask_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [ADDR_W-1:0]   addr_q;   // base_addr + idx*stride, advanced incrementally
  logic [VL_W-1:0]     vl_q;
  logic [VL_W-1:0]     idx;      // element index (mem ops) or chunk base (ALU)

  logic [VL_W-1:0]     eff_vl;
  logic [VL_W-1:0]     idx_nx;
  logic [EL_W-1:0]     idx_el;
  logic [EL_W-1:0]     nx_el;
  logic [ADDR_W-1:0]   addr_nx;
  logic                act_cur;
  logic                act_nx;
  logic                act_first;

  assign eff_vl  = (vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : vl;
  assign idx_nx  = idx + VL_W'(1);
  assign idx_el  = idx[EL_W-1:0];
  assign nx_el   = idx_nx[EL_W-1:0];
  assign addr_nx = addr_q + stride_q;

  // Element activity from bit 0 of v0; the first store element is judged
  // from the live issue inputs because nothing is latched yet.
  assign act_cur   = !mask_q  || rf[0][idx_el][0];
  assign act_nx    = !mask_q  || rf[0][nx_el][0];
  assign act_first = !mask_en || rf[0][0][0];

  logic [VL_W-1:0]       lane_idx [NUM_LANES];
  logic [EL_W-1:0]       lane_el  [NUM_LANES];
  logic [DATA_WIDTH-1:0] lane_res [NUM_LANES];
  logic [NUM_LANES-1:0]  lane_we;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_idx[l] = idx + VL_W'(l);
    assign lane_el[l]  = lane_idx[l][EL_W-1:0];
    assign lane_we[l]  = (state == ALU) && (lane_idx[l] < vl_q) &&
                         (!mask_q || rf[0][lane_el[l]][0]);

    vec_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .funct  (funct_q),
      .a      (rf[vs1_q][lane_el[l]]),
      .b      (rf[vs2_q][lane_el[l]]),
      .result (lane_res[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      funct_q   <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      mask_q    <= 1'b0;
      stride_q  <= '0;
      addr_q    <= '0;
      vl_q      <= '0;
      idx       <= '0;
      rf        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            funct_q  <= funct;
            vd_q     <= vd;
            vs1_q    <= vs1;
            vs2_q    <= vs2;
            mask_q   <= mask_en;
            stride_q <= stride;
            addr_q   <= base_addr;
            vl_q     <= eff_vl;
            idx      <= '0;
            if (!is_legal(funct) || eff_vl == '0) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= !is_legal(funct);
            end else if (is_alu(funct)) begin
              state <= ALU;
              busy  <= 1'b1;
            end else if (funct == VLD) begin
              state    <= LD_REQ;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= base_addr;
            end else begin
              // Masked-off store elements present mem_req=0 for one cycle.
              state     <= ST_REQ;
              busy      <= 1'b1;
              mem_req   <= act_first;
              mem_we    <= 1'b1;
              mem_addr  <= base_addr;
              mem_wdata <= rf[vs2][0];
            end
          end
        end

        ALU: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_we[l]) rf[vd_q][lane_el[l]] <= lane_res[l];
          end
          if (idx + VL_W'(NUM_LANES) >= vl_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + VL_W'(NUM_LANES);
          end
        end

        LD_REQ: begin
          if (mem_gnt) begin
            state   <= LD_WAIT;
            mem_req <= 1'b0;
          end
        end

        LD_WAIT: begin
          if (mem_rvalid) begin
            if (act_cur) rf[vd_q][idx_el] <= mem_rdata;
            idx    <= idx_nx;
            addr_q <= addr_nx;
            if (idx_nx == vl_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= LD_REQ;
              mem_req  <= 1'b1;
              mem_addr <= addr_nx;
            end
          end
        end

        ST_REQ: begin
          if (!mem_req || mem_gnt) begin
            idx    <= idx_nx;
            addr_q <= addr_nx;
            if (idx_nx == vl_q) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end else begin
              mem_req   <= act_nx;
              mem_addr  <= addr_nx;
              mem_wdata <= rf[vs2_q][nx_el];
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
`timescale 1ns/1ps
module tb_vector_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  funct;
  logic [2:0]  vd, vs1, vs2;
  logic [4:0]  vl;
  logic        mask_en;
  logic [31:0] base_addr, stride;
  logic        busy, done, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  vector_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .vd(vd), .vs1(vs1), .vs2(vs2), .vl(vl), .mask_en(mask_en),
    .base_addr(base_addr), .stride(stride),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Reference state: memory image and architectural register contents.
  bit [31:0] mem [bit [31:0]];
  bit [31:0] mref [8][16];

  int npass = 0, nfail = 0, ntot = 0;
  int gnt_delay = 0, rv_delay = 1;
  int grant_cnt = 0;
  bit [31:0] gaddr_q[$];

  int last_cyc, last_grants;
  logic last_err, busy_at1, busy_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory slave: grant after gnt_delay waiting cycles, load data rv_delay cycles after grant.
  initial begin
    int wcnt, rcnt;
    bit [31:0] rpend, ca, cw;
    logic cwe;
    wcnt = 0; rcnt = 0; rpend = 0; ca = 0; cw = 0; cwe = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin mem_rvalid = 1; mem_rdata = rpend; end
      end
      if (mem_req === 1'b1) begin
        if (wcnt == 0) begin
          ca = mem_addr; cwe = mem_we; cw = mem_wdata;
        end else begin
          chk("hold_addr", mem_addr, ca);
          chk("hold_we", {31'b0, mem_we}, {31'b0, cwe});
          if (cwe) chk("hold_wdata", mem_wdata, cw);
        end
        if (wcnt >= gnt_delay) begin
          mem_gnt = 1; wcnt = 0; grant_cnt++;
          gaddr_q.push_back(mem_addr);
          if (mem_we) mem[mem_addr] = mem_wdata;
          else begin rpend = mem[mem_addr]; rcnt = rv_delay; end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Reference semantics of one instruction, element by element.
  task automatic mexec(input int f, d, s1, s2, v, input bit m, input bit [31:0] b, st);
    int eff;
    eff = (v > 16) ? 16 : v;
    if (f > 9) return;
    for (int i = 0; i < eff; i++) begin
      bit act;
      bit [31:0] a, bb, r;
      act = !m || mref[0][i][0];
      a = mref[s1][i]; bb = mref[s2][i]; r = 0;
      if (!act || f == 9) continue;
      case (f)
        0: r = a + bb;
        1: r = a - bb;
        2: r = a * bb;
        3: r = a & bb;
        4: r = a | bb;
        5: r = a ^ bb;
        6: r = ($signed(a) < $signed(bb)) ? a : bb;
        7: r = ($signed(a) < $signed(bb)) ? bb : a;
        default: r = mem[b + st * i];
      endcase
      mref[d][i] = r;
    end
  endtask

  task automatic start_op(input int f, d, s1, s2, v, input bit m, input bit [31:0] b, st);
    funct = 4'(f); vd = 3'(d); vs1 = 3'(s1); vs2 = 3'(s2); vl = 5'(v);
    mask_en = m; base_addr = b; stride = st; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    last_cyc = 1;
    while (done !== 1'b1 && last_cyc < 2000) begin
      @(posedge clk); #1;
      last_cyc++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    last_err = err;
    busy_at_done = busy;
  endtask

  task automatic exec(input int f, d, s1, s2, v, input bit m, input bit [31:0] b, st);
    int g0;
    g0 = grant_cnt;
    start_op(f, d, s1, s2, v, m, b, st);
    busy_at1 = busy;
    wait_done();
    last_grants = grant_cnt - g0;
    mexec(f, d, s1, s2, v, m, b, st);
    @(posedge clk); #1;
  endtask

  task automatic dump_check(input int r);
    exec(9, 0, 0, r, 16, 0, 32'h8000, 32'd4);
    for (int i = 0; i < 16; i++)
      chk($sformatf("v%0d[%0d]", r, i), mem[32'h8000 + 4 * i], mref[r][i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; funct = 0; vd = 0; vs1 = 0; vs2 = 0; vl = 0;
    mask_en = 0; base_addr = 0; stride = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(posedge clk); #1;

    // Load/add/store round trip.
    for (int i = 0; i < 16; i++) begin
      mem[32'h100 + 4 * i] = i + 1;
      mem[32'h140 + 4 * i] = 100 + i;
    end
    exec(8, 1, 0, 0, 16, 0, 32'h100, 32'd4);
    exec(8, 2, 0, 0, 16, 0, 32'h140, 32'd4);
    exec(0, 3, 1, 2, 16, 0, 0, 0);
    chk("vadd_latency", last_cyc, 5);
    chk("vadd_busy", {31'b0, busy_at1}, 1);
    chk("vadd_busy_at_done", {31'b0, busy_at_done}, 0);
    exec(9, 0, 0, 3, 16, 0, 32'h200, 32'd4);
    chk("vst_grants", last_grants, 16);
    for (int i = 0; i < 16; i++) chk("sum_mem", mem[32'h200 + 4 * i], 101 + 2 * i);

    // Masked signed max and masked store.
    for (int i = 0; i < 16; i++) begin
      mem[32'h300 + 4 * i] = (i % 2 == 0) ? 1 : 0;
      mem[32'h340 + 4 * i] = -5;
      mem[32'h380 + 4 * i] = 3;
      mem[32'h400 + 4 * i] = 32'hDEAD0000 + i;
    end
    exec(8, 0, 0, 0, 16, 0, 32'h300, 32'd4);
    exec(8, 1, 0, 0, 16, 0, 32'h340, 32'd4);
    exec(8, 2, 0, 0, 16, 0, 32'h380, 32'd4);
    exec(7, 3, 1, 2, 16, 1, 0, 0);
    dump_check(3);
    for (int i = 0; i < 16; i++)
      chk("vmax_masked", mem[32'h8000 + 4 * i], (i % 2 == 0) ? 3 : 101 + 2 * i);
    exec(9, 0, 0, 3, 16, 1, 32'h400, 32'd4);
    chk("masked_vst_grants", last_grants, 8);
    for (int i = 0; i < 16; i++)
      chk("masked_vst_mem", mem[32'h400 + 4 * i], (i % 2 == 0) ? 3 : 32'hDEAD0000 + i);

    // Backpressure with negative stride.
    gnt_delay = 3; rv_delay = 2;
    for (int i = 0; i < 5; i++) mem[32'h10 - 4 * i] = $urandom;
    gaddr_q.delete();
    exec(8, 4, 0, 0, 5, 0, 32'h10, 32'hFFFFFFFC);
    chk("bp_grants", last_grants, 5);
    for (int i = 0; i < 5; i++) chk("bp_addr", gaddr_q[i], 32'h10 - 4 * i);
    gnt_delay = 0; rv_delay = 1;
    dump_check(4);

    // vl = 0.
    exec(0, 5, 1, 2, 0, 0, 0, 0);
    chk("vl0_alu_latency", last_cyc, 1);
    exec(8, 5, 0, 0, 0, 0, 32'h100, 32'd4);
    chk("vl0_ld_latency", last_cyc, 1);
    chk("vl0_ld_grants", last_grants, 0);

    // vl = 20 clamps to 16.
    exec(9, 0, 0, 1, 20, 0, 32'h600, 32'd4);
    chk("vl20_grants", last_grants, 16);
    exec(0, 5, 1, 2, 20, 0, 0, 0);
    chk("vl20_latency", last_cyc, 5);
    dump_check(5);

    // vl = 6 partial.
    exec(5, 6, 1, 2, 6, 0, 0, 0);
    dump_check(6);

    // Multiply overflow.
    for (int i = 0; i < 16; i++) begin
      mem[32'h700 + 4 * i] = 32'h80000000;
      mem[32'h740 + 4 * i] = 2;
    end
    exec(8, 7, 0, 0, 16, 0, 32'h700, 32'd4);
    exec(8, 4, 0, 0, 16, 0, 32'h740, 32'd4);
    exec(2, 7, 7, 4, 16, 0, 0, 0);
    dump_check(7);
    chk("vmul_wrap", mem[32'h8000], 0);

    // Address wrap.
    gaddr_q.delete();
    exec(9, 0, 0, 1, 2, 0, 32'hFFFFFFFC, 32'd4);
    chk("wrap_addr0", gaddr_q[0], 32'hFFFFFFFC);
    chk("wrap_addr1", gaddr_q[1], 32'h0);

    // Illegal opcode.
    exec(12, 1, 2, 3, 16, 0, 32'h100, 32'd4);
    chk("illegal_err", {31'b0, last_err}, 1);
    chk("illegal_latency", last_cyc, 1);
    chk("illegal_grants", last_grants, 0);
    chk("illegal_err_pulse", {31'b0, err}, 0);
    dump_check(1);

    // Second start while busy is ignored.
    gnt_delay = 2; rv_delay = 2;
    start_op(8, 5, 0, 0, 4, 0, 32'h100, 32'd4);
    repeat (2) begin @(posedge clk); #1; end
    start_op(0, 6, 1, 2, 16, 0, 0, 0);
    wait_done();
    mexec(8, 5, 0, 0, 4, 0, 32'h100, 32'd4);
    @(posedge clk); #1;
    gnt_delay = 0; rv_delay = 1;
    dump_check(5);
    dump_check(6);

    // Randomized instruction mix.
    for (int a = 32'h1E00; a < 32'h2200; a += 4) mem[a] = $urandom;
    exec(8, 0, 0, 0, 16, 0, 32'h2000, 32'd4);
    for (int n = 0; n < 30; n++) begin
      int f, st_sel;
      bit [31:0] st;
      f = $urandom_range(0, 8);
      st_sel = $urandom_range(0, 3);
      st = (st_sel == 0) ? 32'd4 : (st_sel == 1) ? 32'hFFFFFFFC : (st_sel == 2) ? 32'd8 : 32'd0;
      exec(f, $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 20), 1'($urandom_range(0, 1)),
           32'h2000 + ($urandom_range(0, 63) << 2), st);
    end
    for (int r = 0; r < 8; r++) dump_check(r);

    // Asynchronous reset during LD_WAIT.
    rv_delay = 6;
    start_op(8, 3, 0, 0, 16, 0, 32'h100, 32'd4);
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_busy", {31'b0, busy}, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_req", {31'b0, mem_req}, 0);
    chk("arst_done", {31'b0, done}, 0);
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 16; i++) mref[r][i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (8) begin @(posedge clk); #1; end
    rv_delay = 1;
    dump_check(3);
    dump_check(0);
    exec(8, 3, 0, 0, 16, 0, 32'h100, 32'd4);
    dump_check(3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
